lr_shift_pipe: RTL and testbench

- Pipelined, multi-mode bit shifter. Successor to the combinational left/right shifter pair.
- Adds arithmetic-right and rotate modes, a configurable number of register stages, and a valid/ready stream handshake with per-stage bubble collapsing.
- Sits between stream producers and consumers in datapaths that need a shift at high clock rates.

---
 rtl/lr_shift_pipe_pkg.sv | 17 +
 rtl/shift_level_group.sv | 34 +++
 rtl/lr_shift_pipe.sv | 92 +++++++++
 tb/tb_lr_shift_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_shift_pipe_pkg.sv
// lr_shift_defs: shift mode encoding and a constant clog2 helper shared by the shifter pipeline.
package lr_shift_defs;
    typedef enum logic [2:0] {
        LSL = 3'd0,
        LSR = 3'd1,
        ASR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/shift_level_group.sv
// shift_level_group: combinational mux levels first..first+count-1, level k shifting by 2^k.
module shift_level_group
    import lr_shift_defs::*;
#(
    parameter int width = 8,
    parameter int first = 0,
    parameter int count = 1
) (
    input  logic [width-1:0]        i_bits,
    input  logic [clog2(width)-1:0] i_shift,
    input  logic [2:0]              i_mode,
    input  logic                    i_sign,
    output logic [width-1:0]        o_bits
);
    localparam int lvls = clog2(width);

    // ASR fills from the sign captured at input, not the current MSB of the partial result.
    function automatic logic [width-1:0] lvl_shift(input logic [width-1:0] d, input int n,
                                                   input logic [2:0] m, input logic s);
        logic [width-1:0] fill;
        fill = s ? ~({width{1'b1}} >> n) : '0;
        return m == LSR ? d >> n :
               m == ASR ? (d >> n) | fill :
               m == ROL ? (d << n) | (d >> (width - n)) :
               m == ROR ? (d >> n) | (d << (width - n)) : d << n;
    endfunction

    always_comb begin
        o_bits = i_bits;
        for (int k = 0; k < lvls; k++)
            if (k >= first && k < first + count && i_shift[k])
                o_bits = lvl_shift(o_bits, 1 << k, i_mode, i_sign);
    end
endmodule

// File: rtl/lr_shift_pipe.sv
// lr_shift_pipe: pipelined LSL/LSR/ASR/ROL/ROR shifter with valid/ready and bubble-collapsing stages.
module lr_shift_pipe
    import lr_shift_defs::*;
#(
    parameter int width  = 8,
    parameter int stages = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [width-1:0]        i_bits,
    input  logic [clog2(width)-1:0] i_shift,
    input  logic [2:0]              i_mode,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [width-1:0]        o_bits
);
    localparam int lvls = clog2(width);
    localparam int per  = (lvls + stages - 1) / stages;

    logic [stages-1:0] r_valid, r_sign;
    logic [width-1:0]  r_bits  [stages];
    logic [lvls-1:0]   r_shift [stages];
    logic [2:0]        r_mode  [stages];

    logic [stages-1:0] w_en, w_v, w_sg;
    logic [width-1:0]  w_d  [stages];
    logic [width-1:0]  w_y  [stages];
    logic [lvls-1:0]   w_sh [stages];
    logic [2:0]        w_m  [stages];

    // A stage may load whenever it is empty or its successor is moving.
    always_comb begin
        logic e;
        e = o_ready;
        for (int k = stages - 1; k >= 0; k--) begin
            e = !r_valid[k] || e;
            w_en[k] = e;
        end
        w_v[0]  = i_valid;
        w_d[0]  = i_bits;
        w_sh[0] = i_shift;
        w_m[0]  = i_mode;
        w_sg[0] = i_bits[width-1];
        for (int k = 1; k < stages; k++) begin
            w_v[k]  = r_valid[k-1];
            w_d[k]  = r_bits[k-1];
            w_sh[k] = r_shift[k-1];
            w_m[k]  = r_mode[k-1];
            w_sg[k] = r_sign[k-1];
        end
    end

    for (genvar s = 0; s < stages; s++) begin : g_grp
        localparam int first = s * per;
        localparam int count = first >= lvls ? 0 : (lvls - first < per ? lvls - first : per);
        shift_level_group #(.width(width), .first(first), .count(count)) u_grp (
            .i_bits (w_d[s]),
            .i_shift(w_sh[s]),
            .i_mode (w_m[s]),
            .i_sign (w_sg[s]),
            .o_bits (w_y[s])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_sign  <= '0;
            for (int k = 0; k < stages; k++) begin
                r_bits[k]  <= '0;
                r_shift[k] <= '0;
                r_mode[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < stages; k++) begin
                if (w_en[k]) r_valid[k] <= w_v[k];
                if (w_en[k] && w_v[k]) begin
                    r_bits[k]  <= w_y[k];
                    r_shift[k] <= w_sh[k];
                    r_mode[k]  <= w_m[k];
                    r_sign[k]  <= w_sg[k];
                end
            end
        end
    end

    assign i_ready = w_en[0];
    assign o_valid = r_valid[stages-1];
    assign o_bits  = r_bits[stages-1];
endmodule

// File: tb/tb_lr_shift_pipe.sv
// tb_lr_shift_pipe: three configurations (8/1, 16/2, 8/3) checked against an arithmetic shift model.
module tb_lr_shift_pipe;
    logic clk = 1'b0, rst = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    logic a_iv = 1'b0, a_ir, a_ov, a_or = 1'b1;
    logic [7:0] a_ib = '0, a_ob;
    logic [2:0] a_sh = '0, a_md = '0;
    logic b_iv = 1'b0, b_ir, b_ov, b_or = 1'b1;
    logic [15:0] b_ib = '0, b_ob;
    logic [3:0] b_sh = '0;
    logic [2:0] b_md = '0;
    logic c_iv = 1'b0, c_ir, c_ov, c_or = 1'b0;
    logic [7:0] c_ib = '0, c_ob;
    logic [2:0] c_sh = '0, c_md = '0;
    logic [7:0] mode_exp [5] = '{8'hB0, 8'h12, 8'hF2, 8'hB4, 8'hD2};

    lr_shift_pipe #(.width(8), .stages(1)) u_a (.clk(clk), .rst(rst), .i_valid(a_iv), .i_ready(a_ir),
        .i_bits(a_ib), .i_shift(a_sh), .i_mode(a_md), .o_valid(a_ov), .o_ready(a_or), .o_bits(a_ob));
    lr_shift_pipe #(.width(16), .stages(2)) u_b (.clk(clk), .rst(rst), .i_valid(b_iv), .i_ready(b_ir),
        .i_bits(b_ib), .i_shift(b_sh), .i_mode(b_md), .o_valid(b_ov), .o_ready(b_or), .o_bits(b_ob));
    lr_shift_pipe #(.width(8), .stages(3)) u_c (.clk(clk), .rst(rst), .i_valid(c_iv), .i_ready(c_ir),
        .i_bits(c_ib), .i_shift(c_sh), .i_mode(c_md), .o_valid(c_ov), .o_ready(c_or), .o_bits(c_ob));

    function automatic int ref_shift(input int w, input int d, input int n, input int m);
        int mask, sd;
        mask = (1 << w) - 1;
        d = d & mask;
        sd = ((d >> (w - 1)) & 1) != 0 ? d - (1 << w) : d;
        case (m)
            1: return d >> n;
            2: return (sd >>> n) & mask;
            3: return ((d << n) | (d >> (w - n))) & mask;
            4: return ((d >> n) | (d << (w - n))) & mask;
            default: return (d << n) & mask;
        endcase
    endfunction

    task automatic a_beat(input logic [7:0] d, input logic [2:0] sh, input logic [2:0] md,
                          output logic v, output logic [7:0] q);
        a_ib = d; a_sh = sh; a_md = md; a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0; v = a_ov; q = a_ob;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks += 9;
        if (a_ov !== 1'b0 || a_ob !== 8'h00 || a_ir !== 1'b1) begin
            errors += 1; $display("FAIL reset_a got v=%b b=%h r=%b want 0 00 1", a_ov, a_ob, a_ir);
        end
        if (b_ov !== 1'b0 || b_ob !== 16'h0000 || b_ir !== 1'b1) begin
            errors += 1; $display("FAIL reset_b got v=%b b=%h r=%b want 0 0000 1", b_ov, b_ob, b_ir);
        end
        if (c_ov !== 1'b0 || c_ob !== 8'h00 || c_ir !== 1'b1) begin
            errors += 1; $display("FAIL reset_c got v=%b b=%h r=%b want 0 00 1", c_ov, c_ob, c_ir);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_modes;
        logic v;
        logic [7:0] q;
        for (int m = 0; m < 5; m++) begin
            a_beat(8'h96, 3'd3, 3'(m), v, q);
            checks += 2;
            if (v !== 1'b1) begin errors++; $display("FAIL mode%0d_latency got %b want 1", m, v); end
            if (q !== mode_exp[m]) begin errors++; $display("FAIL mode%0d_value got %h want %h", m, q, mode_exp[m]); end
        end
    endtask

    task automatic test_boundaries;
        logic v;
        logic [7:0] q, d;
        logic [2:0] sh, md;
        for (int m = 0; m < 5; m++) begin
            d = 8'($urandom);
            a_beat(d, 3'd0, 3'(m), v, q);
            checks++;
            if (q !== d) begin errors++; $display("FAIL shift0_mode%0d got %h want %h", m, q, d); end
        end
        a_beat(8'h80, 3'd7, 3'd2, v, q);
        checks++;
        if (q !== 8'hFF) begin errors++; $display("FAIL asr_by7 got %h want ff", q); end
        a_beat(8'h01, 3'd7, 3'd0, v, q);
        checks++;
        if (q !== 8'h80) begin errors++; $display("FAIL lsl_by7 got %h want 80", q); end
        for (int m = 5; m < 8; m++) begin
            d = 8'($urandom); sh = 3'($urandom_range(1, 7));
            a_beat(d, sh, 3'(m), v, q);
            checks++;
            if (q !== 8'(ref_shift(8, int'(d), int'(sh), 0)))
                begin errors++; $display("FAIL undef_mode%0d got %h want %h", m, q, 8'(ref_shift(8, int'(d), int'(sh), 0))); end
        end
        for (int j = 0; j < 30; j++) begin
            d = 8'($urandom); sh = 3'($urandom); md = 3'($urandom_range(0, 4));
            a_beat(d, sh, md, v, q);
            checks++;
            if (q !== 8'(ref_shift(8, int'(d), int'(sh), int'(md))))
                begin errors++; $display("FAIL rand_a m=%0d s=%0d d=%h got %h want %h", md, sh, d, q, 8'(ref_shift(8, int'(d), int'(sh), int'(md)))); end
        end
    endtask

    task automatic test_back_to_back;
        int q[$];
        logic [15:0] d;
        logic [3:0] sh;
        logic [2:0] md;
        b_or = 1'b1;
        for (int j = 0; j < 12; j++) begin
            checks++;
            if (b_ov !== (j >= 2 && j <= 9)) begin errors++; $display("FAIL b2b_valid cyc %0d got %b want %b", j, b_ov, (j >= 2 && j <= 9)); end
            if (b_ov === 1'b1) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL b2b_extra cyc %0d got %h want none", j, b_ob); end
                else begin
                    if (b_ob !== 16'(q[0])) begin errors++; $display("FAIL b2b_data cyc %0d got %h want %h", j, b_ob, 16'(q[0])); end
                    void'(q.pop_front());
                end
            end
            if (j < 8) begin
                d = 16'($urandom); sh = 4'($urandom); md = 3'($urandom_range(0, 7));
                b_ib = d; b_sh = sh; b_md = md; b_iv = 1'b1;
                checks++;
                if (b_ir !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc %0d got %b want 1", j, b_ir); end
                q.push_back(ref_shift(16, int'(d), int'(sh), int'(md)));
            end else b_iv = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_capacity;
        int q[$];
        logic [7:0] d;
        logic [2:0] sh, md;
        c_or = 1'b0;
        for (int j = 0; j < 6; j++) begin
            d = 8'($urandom); sh = 3'($urandom); md = 3'($urandom_range(0, 4));
            c_ib = d; c_sh = sh; c_md = md; c_iv = 1'b1;
            checks += 2;
            if (c_ir !== (j < 3)) begin errors++; $display("FAIL cap_ready cyc %0d got %b want %b", j, c_ir, (j < 3)); end
            if (c_ov !== (j >= 3)) begin errors++; $display("FAIL cap_valid cyc %0d got %b want %b", j, c_ov, (j >= 3)); end
            if (j >= 3 && q.size() > 0) begin
                checks++;
                if (c_ob !== 8'(q[0])) begin errors++; $display("FAIL cap_hold cyc %0d got %h want %h", j, c_ob, 8'(q[0])); end
            end
            if (c_ir === 1'b1) q.push_back(ref_shift(8, int'(d), int'(sh), int'(md)));
            @(negedge clk);
        end
        c_iv = 1'b0; c_or = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (c_ov === 1'b1) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL cap_dup cyc %0d got %h want none", j, c_ob); end
                else begin
                    if (c_ob !== 8'(q[0])) begin errors++; $display("FAIL cap_drain cyc %0d got %h want %h", j, c_ob, 8'(q[0])); end
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL cap_lost got %0d left want 0", q.size()); end
    endtask

    task automatic test_bubble;
        int q[$];
        logic [7:0] d;
        logic [2:0] sh, md;
        c_or = 1'b0;
        d = 8'($urandom); sh = 3'($urandom); md = 3'($urandom_range(0, 4));
        c_ib = d; c_sh = sh; c_md = md; c_iv = 1'b1;
        q.push_back(ref_shift(8, int'(d), int'(sh), int'(md)));
        @(negedge clk);
        c_iv = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (c_ov !== 1'b1 || c_ob !== 8'(q[0])) begin errors++; $display("FAIL bub_stalled got %b %h want 1 %h", c_ov, c_ob, 8'(q[0])); end
        for (int j = 0; j < 4; j++) begin
            d = 8'($urandom); sh = 3'($urandom); md = 3'($urandom_range(0, 4));
            c_ib = d; c_sh = sh; c_md = md; c_iv = 1'b1;
            checks++;
            if (c_ir !== (j < 2)) begin errors++; $display("FAIL bub_ready cyc %0d got %b want %b", j, c_ir, (j < 2)); end
            if (c_ir === 1'b1) q.push_back(ref_shift(8, int'(d), int'(sh), int'(md)));
            @(negedge clk);
        end
        c_iv = 1'b0; c_or = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (c_ov === 1'b1) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL bub_dup cyc %0d got %h want none", j, c_ob); end
                else begin
                    if (c_ob !== 8'(q[0])) begin errors++; $display("FAIL bub_drain cyc %0d got %h want %h", j, c_ob, 8'(q[0])); end
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL bub_lost got %0d left want 0", q.size()); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic [2:0] sh, md;
        c_or = 1'b0;
        for (int j = 0; j < 2; j++) begin
            c_ib = 8'($urandom); c_sh = 3'($urandom); c_md = 3'($urandom_range(0, 4)); c_iv = 1'b1;
            @(negedge clk);
        end
        c_iv = 1'b0;
        @(negedge clk);
        checks++;
        if (c_ov !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", c_ov); end
        #2 rst = 1'b0;
        #1;
        checks += 3;
        if (c_ov !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", c_ov); end
        if (c_ob !== 8'h00) begin errors++; $display("FAIL rmid_bits got %h want 00", c_ob); end
        if (c_ir !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", c_ir); end
        @(negedge clk);
        rst = 1'b1; c_or = 1'b1;
        d = 8'($urandom); sh = 3'($urandom); md = 3'($urandom_range(0, 4));
        c_ib = d; c_sh = sh; c_md = md; c_iv = 1'b1;
        @(negedge clk);
        c_iv = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            checks++;
            if (c_ov !== (j == 3)) begin errors++; $display("FAIL rmid_lat cyc %0d got %b want %b", j, c_ov, (j == 3)); end
            if (j == 3) begin
                checks++;
                if (c_ob !== 8'(ref_shift(8, int'(d), int'(sh), int'(md))))
                    begin errors++; $display("FAIL rmid_data got %h want %h", c_ob, 8'(ref_shift(8, int'(d), int'(sh), int'(md)))); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_boundaries();
        test_back_to_back();
        test_capacity();
        test_bubble();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
